bcd_time_display_scan: RTL and testbench
========================================

Name: bcd_time_display_scan

Overview:
- Consumes the six BCD time digits (hour1, hour0, min1, min0, sec1, sec0) from the time-of-day counter.
- Drives a 6-digit multiplexed common-anode 7-segment display.
- Once per scan frame it snapshots all six digits so the display never shows a torn time.
- It then time-multiplexes the digits with an anti-ghosting blank interval, a blinking colon (decimal points) and optional hour leading-zero suppression.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot. Must be ≥ 2.
- BLANK_CYC, 4: cycles at the start of each slot during which all anodes are off. Must be < SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- hour1, hour0, min1, min0, sec1, sec0  in  4 each  BCD digits from the time counter
- en  in  1  display enable; low forces all anodes off
- blank_lead  in  1  suppress hour1 when its snapshot is 0
- an_n  out  6  active-low digit anodes; bit k = slot k
- seg_n  out  7  active-low segments; bit0=a … bit6=g
- dp_n  out  1  active-low decimal point
- frame_tick  out  1  one-cycle pulse marking a snapshot

Behaviour:
- **Slot mapping:** slot0=sec0, slot1=sec1, slot2=min0, slot3=min1, slot4=hour0, slot5=hour1.
- **State registers:** prescaler p (0..SCAN_DIV-1), slot s (0..5), 24-bit shadow, output registers.
- **Reset (async, immediate, including mid-operation):**
  - p=SCAN_DIV-1, s=5, shadow=0.
  - an_n=6'h3F, seg_n=7'h7F, dp_n=1, frame_tick=0.
- **Advance:** each clk edge, p increments.
  - When p==SCAN_DIV-1: p→0 and s→s+1, wrapping 5→0.
- **Snapshot:** on the edge where s wraps 5→0, all six inputs are captured into the shadow and frame_tick=1 for that one cycle.
  - Because of the reset values, this happens on the first edge after rst_n release.
  - Inputs changing mid-frame are ignored until the next snapshot.
- **Frame length:** 6×SCAN_DIV cycles. frame_tick period is exactly 6×SCAN_DIV cycles.
- **Output latency:** an_n/seg_n/dp_n are registered from the (s, p, shadow) values of the previous cycle, i.e. one cycle of latency.
- **Anode rule:** an_n[s]=0 iff en=1, p ≥ BLANK_CYC, and not (s==5 && blank_lead && shadow.hour1==0). All other anode bits are 1.
- **Segment decode:** seg_n is decoded from the shadow digit of slot s, independent of blanking.
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Codes 10–15 show a dash: 7'h3F (g only).
- **Colon:** dp_n=0 iff s∈{2,4} and shadow.sec0[0]==0, i.e. the colon blinks at 1 Hz with seconds. Otherwise dp_n=1.
- **en low:** p, s, snapshots and frame_tick continue running; only the anodes are forced off.
- **Width rule:** p width = clog2(SCAN_DIV). No arithmetic on BCD values.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - the segment pattern constants SEG_0..SEG_9 and SEG_DASH;
  - the slot index constants SLOT_SEC0..SLOT_HOUR1;
  - the digit-count constant NUM_DIGITS=6.
- One combinational sub-module, bcd_to_seg7: 4-bit BCD in, 7-bit active-low segments out, dash for invalid codes.
- Prescaler, slot counter, snapshot and output registers stay in the top.

Test Plan (SCAN_DIV=8, BLANK_CYC=2 unless stated):
- **Reset/first frame:** hold rst_n low, then release with inputs 1,2:3,4:5,6 and en=1.
  - Outputs stay all-off (an_n=6'h3F) during reset.
  - frame_tick is high the cycle after the first edge.
  - Slot0 shows an_n=6'h3E with seg_n=7'h02 for 6 cycles, after 2 blank cycles.
  - Slots 1..5 show 5,4,3,2,1 in sequence.
- **Snapshot coherence:** change sec0 from 6 to 7 mid-frame (during slot3).
  - The remainder of the frame is unchanged.
  - The next frame shows 7 in slot0 and dp_n=1 on slots 2/4 (odd sec0).
  - frame_tick period measures 48 cycles.
- **Invalid/lead blank:** hour1=0 with blank_lead=1 → an_n[5] is never low; blank_lead=0 → slot5 shows seg_n=7'h40.
  - sec1=4'hC → slot1 shows seg_n=7'h3F.
- **Enable:** drop en for 2 frames → an_n=6'h3F throughout while frame_tick keeps pulsing every 48 cycles. Raise en → display resumes at the current slot with no restart.
- **Async reset mid-slot:** assert rst_n low between clock edges during slot3 → outputs go to reset values immediately. Release → a snapshot occurs on the first edge and scanning restarts at slot0.
- **Long divider:** SCAN_DIV=50000, BLANK_CYC=4 → each anode is low for exactly 49996 consecutive cycles per slot.

Source files
------------

// File: rtl/bcd_time_display_scan_pkg.sv
// Shared constants, types and helpers for the BCD time display scanner.
// Segment patterns are active-low, bit0=a .. bit6=g.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;
  typedef logic [2:0] slot_t;

  typedef struct packed {
    bcd_t hour1;
    bcd_t hour0;
    bcd_t min1;
    bcd_t min0;
    bcd_t sec1;
    bcd_t sec0;
  } time_bcd_t;

  localparam slot_t SLOT_SEC0  = 3'd0;
  localparam slot_t SLOT_SEC1  = 3'd1;
  localparam slot_t SLOT_MIN0  = 3'd2;
  localparam slot_t SLOT_MIN1  = 3'd3;
  localparam slot_t SLOT_HOUR0 = 3'd4;
  localparam slot_t SLOT_HOUR1 = 3'd5;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = '1;

  // Digit shown in a given slot; unused slot codes fall back to hour1.
  function automatic bcd_t slot_digit(time_bcd_t t, slot_t s);
    case (s)
      SLOT_SEC0:  return t.sec0;
      SLOT_SEC1:  return t.sec1;
      SLOT_MIN0:  return t.min0;
      SLOT_MIN1:  return t.min1;
      SLOT_HOUR0: return t.hour0;
      default:    return t.hour1;
    endcase
  endfunction

endpackage

// File: rtl/bcd_time_display_scan_if.sv
// Bundle between the time-of-day counter side and the display scanner.
interface bcd_time_display_scan_if;
  import bcd_disp_pkg::*;

  bcd_t hour1;
  bcd_t hour0;
  bcd_t min1;
  bcd_t min0;
  bcd_t sec1;
  bcd_t sec0;
  logic en;
  logic blank_lead;
  logic [NUM_DIGITS-1:0] an_n;
  logic [6:0] seg_n;
  logic dp_n;
  logic frame_tick;

  modport master (
    output hour1, hour0, min1, min0, sec1, sec0, en, blank_lead,
    input  an_n, seg_n, dp_n, frame_tick
  );

  modport slave (
    input  hour1, hour0, min1, min0, sec1, sec0, en, blank_lead,
    output an_n, seg_n, dp_n, frame_tick
  );

endinterface

// File: rtl/bcd_time_display_scan_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_time_display_scan.sv
// Six-digit multiplexed display scanner: per-frame snapshot of the time digits,
// per-slot blank interval, blinking colon and optional hour1 suppression.
module bcd_time_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_time_display_scan_if.slave   disp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);

  logic [PW-1:0]         p_q, p_d;
  slot_t                 s_q, s_d;
  time_bcd_t             shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  tick_q, tick_d;

  time_bcd_t live;
  bcd_t      cur_digit;
  logic      anode_en;
  logic      lead_blank;

  assign live = '{hour1: disp.hour1, hour0: disp.hour0,
                  min1:  disp.min1,  min0:  disp.min0,
                  sec1:  disp.sec1,  sec0:  disp.sec0};

  // Slot 5 wraps to slot 0 and that same edge captures the coherent time.
  always_comb begin
    p_d      = p_q + PW'(1);
    s_d      = s_q;
    shadow_d = shadow_q;
    tick_d   = 1'b0;
    if (p_q == P_LAST) begin
      p_d = '0;
      if (s_q == SLOT_HOUR1) begin
        s_d      = SLOT_SEC0;
        shadow_d = live;
        tick_d   = 1'b1;
      end else begin
        s_d = s_q + 3'd1;
      end
    end
  end

  assign cur_digit = slot_digit(shadow_q, s_q);

  bcd_to_seg7 u_dec (
    .bcd   (cur_digit),
    .seg_n (seg_d)
  );

  always_comb begin
    lead_blank = (s_q == SLOT_HOUR1) && disp.blank_lead && (shadow_q.hour1 == 4'd0);
    anode_en   = disp.en && (p_q >= P_BLANK) && !lead_blank;
    // Colon dots sit on min0 and hour0 and are lit on even seconds.
    dp_d       = !(((s_q == SLOT_MIN0) || (s_q == SLOT_HOUR0)) && !shadow_q.sec0[0]);
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign an_d[gi] = !(anode_en && (s_q == slot_t'(gi)));
  end

  // Reset parks the scan at the last tick of slot 5 so the first edge snapshots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q      <= P_LAST;
      s_q      <= SLOT_HOUR1;
      shadow_q <= '0;
      an_q     <= ANODES_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      p_q      <= p_d;
      s_q      <= s_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      tick_q   <= tick_d;
    end
  end

  assign disp.an_n       = an_q;
  assign disp.seg_n      = seg_q;
  assign disp.dp_n       = dp_q;
  assign disp.frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_time_display_scan.sv
// Table-driven bench for bcd_time_display_scan (SCAN_DIV=8, BLANK_CYC=2) plus
// a second instance at the default divider for the long anode-width check.
module tb_bcd_time_display_scan;
  import bcd_disp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  always #5 clk = ~clk;

  bcd_time_display_scan_if bus ();
  bcd_time_display_scan_if bus2 ();

  bcd_time_display_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (bus.slave)
  );

  bcd_time_display_scan #(.SCAN_DIV(50000), .BLANK_CYC(4)) dut_long (
    .clk   (clk),
    .rst_n (rst2_n),
    .disp  (bus2.slave)
  );

  typedef struct {
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       en, bl;
    int         mid_j;
    logic [3:0] mid_s0;
    logic [5:0][6:0] seg;
    logic [5:0] lit;
    logic [5:0] dp;
  } vec_t;

  vec_t tbl[9];
  int   errors = 0;
  int   checks = 0;

  logic [5:0] an_c[48];
  logic [6:0] seg_c[48];
  logic       dp_c[48];

  int cyc = 0;
  int last_tick = -1;
  int tick_period = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n === 1'b1 && bus.frame_tick === 1'b1) begin
      if (last_tick >= 0) tick_period = cyc - last_tick;
      last_tick = cyc;
    end
    if (rst_n !== 1'b1) last_tick = -1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic [3:0] h1, h0, m1, m0, s1, s0,
    input logic en, bl, input int mid_j, input logic [3:0] mid_s0,
    input logic [6:0] g0, g1, g2, g3, g4, g5,
    input logic [5:0] lit, input logic [5:0] dp);
    vec_t v;
    v.h1 = h1; v.h0 = h0; v.m1 = m1; v.m0 = m0; v.s1 = s1; v.s0 = s0;
    v.en = en; v.bl = bl; v.mid_j = mid_j; v.mid_s0 = mid_s0;
    v.seg[0] = g0; v.seg[1] = g1; v.seg[2] = g2;
    v.seg[3] = g3; v.seg[4] = g4; v.seg[5] = g5;
    v.lit = lit; v.dp = dp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bus.hour1 = v.h1; bus.hour0 = v.h0; bus.min1 = v.m1;
    bus.min0 = v.m0;  bus.sec1 = v.s1;  bus.sec0 = v.s0;
    bus.en = v.en;    bus.blank_lead = v.bl;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (bus.frame_tick === 1'b1) break;
      if (n > 200) begin
        chk("frame_tick_timeout", 32'(n), 32'(48));
        break;
      end
    end
  endtask

  // Called at the negedge where frame_tick is seen; sample j = output for scan
  // position slot j/8, prescaler j%8.
  task automatic capture(input int mid_j, input logic [3:0] mid_s0);
    for (int j = 0; j < 47; j++) begin
      if (j == mid_j) bus.sec0 = mid_s0;
      @(negedge clk);
      an_c[j]  = bus.an_n;
      seg_c[j] = bus.seg_n;
      dp_c[j]  = bus.dp_n;
    end
  endtask

  task automatic check_frame(input int idx, input vec_t v);
    logic [5:0] exp_an;
    for (int k = 0; k < 6; k++) begin
      exp_an = v.lit[k] ? ~(6'b000001 << k) : 6'h3F;
      chk($sformatf("v%0d_s%0d_blank_an", idx, k), 32'(an_c[8*k+1]), 32'(6'h3F));
      chk($sformatf("v%0d_s%0d_first_an", idx, k), 32'(an_c[8*k+2]), 32'(exp_an));
      chk($sformatf("v%0d_s%0d_an", idx, k), 32'(an_c[8*k+5]), 32'(exp_an));
      chk($sformatf("v%0d_s%0d_seg", idx, k), 32'(seg_c[8*k+5]), 32'(v.seg[k]));
      chk($sformatf("v%0d_s%0d_dp", idx, k), 32'(dp_c[8*k+5]), 32'(v.dp[k]));
    end
    $display("vec %0d time %h%h:%h%h:%h%h en=%b bl=%b errors=%0d", idx,
             v.h1, v.h0, v.m1, v.m0, v.s1, v.s0, v.en, v.bl, errors);
  endtask

  int run;
  int maxrun;

  initial begin
    tbl[0] = mkv(1,2,3,4,5,6,    1,1,-1,0, 7'h02,7'h12,7'h19,7'h30,7'h24,7'h79, 6'b111111, 6'b101011);
    tbl[1] = mkv(1,2,3,4,5,6,    1,1,28,7, 7'h02,7'h12,7'h19,7'h30,7'h24,7'h79, 6'b111111, 6'b101011);
    tbl[2] = mkv(1,2,3,4,5,7,    1,1,-1,0, 7'h78,7'h12,7'h19,7'h30,7'h24,7'h79, 6'b111111, 6'b111111);
    tbl[3] = mkv(0,9,5,9,4'hC,8, 1,1,-1,0, 7'h00,7'h3F,7'h10,7'h12,7'h10,7'h40, 6'b011111, 6'b101011);
    tbl[4] = mkv(0,9,5,9,4'hC,8, 1,0,-1,0, 7'h00,7'h3F,7'h10,7'h12,7'h10,7'h40, 6'b111111, 6'b101011);
    tbl[5] = mkv(2,3,5,9,5,9,    0,1,-1,0, 7'h10,7'h12,7'h10,7'h12,7'h30,7'h24, 6'b000000, 6'b111111);
    tbl[6] = mkv(2,3,5,9,5,9,    0,1,-1,0, 7'h10,7'h12,7'h10,7'h12,7'h30,7'h24, 6'b000000, 6'b111111);
    tbl[7] = mkv(1,8,0,7,4'hA,1, 1,1,-1,0, 7'h79,7'h3F,7'h78,7'h40,7'h00,7'h79, 6'b111111, 6'b111111);
    tbl[8] = mkv(0,0,0,0,0,0,    1,1,-1,0, 7'h40,7'h40,7'h40,7'h40,7'h40,7'h40, 6'b011111, 6'b101011);

    rst_n = 1'b0;
    rst2_n = 1'b0;
    apply(tbl[0]);
    bus2.hour1 = 4'd1; bus2.hour0 = 4'd2; bus2.min1 = 4'd3;
    bus2.min0 = 4'd4;  bus2.sec1 = 4'd5;  bus2.sec0 = 4'd6;
    bus2.en = 1'b1;    bus2.blank_lead = 1'b0;

    // Reset state and first frame.
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(bus.an_n), 32'(6'h3F));
    chk("rst_seg", 32'(bus.seg_n), 32'(7'h7F));
    chk("rst_dp", 32'(bus.dp_n), 32'(1'b1));
    chk("rst_tick", 32'(bus.frame_tick), 32'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_tick", 32'(bus.frame_tick), 32'(1'b1));
    chk("first_an", 32'(bus.an_n), 32'(6'h3F));
    chk("first_seg", 32'(bus.seg_n), 32'(7'h40));

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i]);
      if (i > 0) wait_tick();
      capture(tbl[i].mid_j, tbl[i].mid_s0);
      if (i == 0) chk("tick_width", 32'(bus.frame_tick), 32'(1'b0));
      check_frame(i, tbl[i]);
    end
    wait_tick();
    chk("tick_period", 32'(tick_period), 32'(48));

    // Enable dropped then raised mid-frame resumes at the current slot.
    bus.en = 1'b0;
    wait_tick();
    chk("en_off_period", 32'(tick_period), 32'(48));
    repeat (20) @(negedge clk);
    chk("en_off_an", 32'(bus.an_n), 32'(6'h3F));
    bus.en = 1'b1;
    @(negedge clk);
    chk("en_resume_an", 32'(bus.an_n), 32'(6'h3B));
    wait_tick();
    chk("en_resume_period", 32'(tick_period), 32'(48));
    $display("enable resume errors=%0d", errors);

    // Asynchronous reset between edges during slot 3.
    repeat (30) @(negedge clk);
    chk("pre_rst_an", 32'(bus.an_n), 32'(6'h37));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(bus.an_n), 32'(6'h3F));
    chk("arst_seg", 32'(bus.seg_n), 32'(7'h7F));
    chk("arst_dp", 32'(bus.dp_n), 32'(1'b1));
    chk("arst_tick", 32'(bus.frame_tick), 32'(1'b0));
    apply(tbl[0]);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_first_tick", 32'(bus.frame_tick), 32'(1'b1));
    capture(-1, 4'd0);
    check_frame(9, tbl[0]);

    // Long divider: anode 0 low for SCAN_DIV-BLANK_CYC consecutive cycles.
    run = 0;
    maxrun = 0;
    @(negedge clk);
    rst2_n = 1'b1;
    for (int c = 0; c < 50010; c++) begin
      @(negedge clk);
      if (bus2.an_n[0] == 1'b0) run++;
      else begin
        if (run > maxrun) maxrun = run;
        run = 0;
      end
    end
    chk("long_run", 32'(maxrun), 32'(49996));
    chk("long_slot1_an", 32'(bus2.an_n), 32'(6'h3D));
    $display("long divider run=%0d errors=%0d", maxrun, errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
